riscv_data_mem_resp: RTL and testbench

//   Data-memory responder for the RISC-V core: the memory side of the core's load/store port.

---
 rtl/riscv_data_mem_resp.sv | 154 +++++++++++++++
 tb/tb_riscv_data_mem_resp.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_data_mem_resp.sv
// Data-memory responder with fixed access latency, sub-word loads/stores and byte-lane masking.
// Optional feature: define MISALIGN_ERR_EN to flag misaligned accesses instead of silently aligning them.
module riscv_data_mem_resp #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    count_reg, count_next;
    logic          accept, access;

    logic          we_reg;
    logic [2:0]    funct3_reg;
    logic [AW+1:0] addr_reg;
    logic [31:0]   wdata_reg;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   mem_word_reg;
    logic [AW-1:0] rd_idx;

    logic          is_byte, is_half, is_word, is_unsigned, misaligned;
    logic [3:0]    byte_en;
    logic [31:0]   store_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   load_data;

    logic          unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    // count_reg holds the number of wait cycles still to spend before the access edge
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        req_ready  = 1'b0;
        accept     = 1'b0;
        access     = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                    count_next = LATENCY[3:0];
                end
            end
            WAIT: begin
                if (count_reg == 4'd0) begin
                    access     = 1'b1;
                    state_next = RESP;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            resp_valid <= access;
            resp_rdata <= (access && !we_reg && !misaligned) ? load_data : 32'd0;
            resp_err   <= access & misaligned;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            we_reg     <= req_we;
            funct3_reg <= req_funct3;
            addr_reg   <= req_addr[AW+1:0];
            wdata_reg  <= req_wdata;
        end
    end

    // Size decode: 011/110/111 fall through to word.
    assign is_byte     = (funct3_reg[1:0] == 2'b00);
    assign is_half     = (funct3_reg[1:0] == 2'b01);
    assign is_word     = ~is_byte & ~is_half;
    assign is_unsigned = funct3_reg[2];

`ifdef MISALIGN_ERR_EN
    assign misaligned = (is_half & addr_reg[0]) | (is_word & (addr_reg[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign byte_en[gi] = is_word
                               | (is_half & (addr_reg[1] == LANE[1]))
                               | (is_byte & (addr_reg[1:0] == LANE));
            assign store_word[8*gi +: 8] = is_word ? wdata_reg[8*gi +: 8]
                                         : is_half ? wdata_reg[8*LANE[0] +: 8]
                                         :           wdata_reg[7:0];
        end
    endgenerate

    // The word is read ahead with the request's own address; nothing else writes it before the access edge.
    assign rd_idx = (state_reg == IDLE) ? req_addr[AW+1:2] : addr_reg[AW+1:2];

    always_ff @(posedge clk) begin
        mem_word_reg <= mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst && access && we_reg && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[addr_reg[AW+1:2]][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

    assign ld_byte = mem_word_reg[{addr_reg[1:0], 3'b000} +: 8];
    assign ld_half = addr_reg[1] ? mem_word_reg[31:16] : mem_word_reg[15:0];

    always_comb begin
        load_data = mem_word_reg;
        if (is_byte) begin
            load_data = is_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        end else if (is_half) begin
            load_data = is_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
        end
    end

endmodule

// File: tb/tb_riscv_data_mem_resp.sv
// Scoreboard bench for riscv_data_mem_resp: one instance at LATENCY=2, one at LATENCY=0.
`timescale 1ns/1ps
module tb_riscv_data_mem_resp;

    localparam int DEPTH = 1024;
    localparam int LAT0  = 2;
    localparam int LAT1  = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    always #5 clk = ~clk;

    riscv_data_mem_resp #(.DEPTH(DEPTH), .LATENCY(LAT0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    riscv_data_mem_resp #(.DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    logic [31:0] mdl [2][DEPTH];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Reference behaviour of one access; updates the model memory for stores.
    function automatic exp_t model(input int d, input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        logic [31:0] word;
        logic [7:0]  b;
        logic [15:0] h;
        logic        mis;
        int          idx, lane;
        idx  = int'(addr[31:2]) % DEPTH;
        lane = int'(addr[1:0]);
        word = mdl[d][idx];
        mis  = 1'b0;
`ifdef MISALIGN_ERR_EN
        if (f3[1:0] == 2'b01 && addr[0]) mis = 1'b1;
        if (f3[1] && addr[1:0] != 2'b00) mis = 1'b1;
`endif
        e.err   = mis;
        e.rdata = 32'd0;
        if (!mis) begin
            if (we) begin
                case (f3[1:0])
                    2'b00:   word[lane*8 +: 8] = wdata[7:0];
                    2'b01:   word[(lane/2)*16 +: 16] = wdata[15:0];
                    default: word = wdata;
                endcase
                mdl[d][idx] = word;
            end else begin
                b = word[lane*8 +: 8];
                h = word[(lane/2)*16 +: 16];
                case (f3[1:0])
                    2'b00:   e.rdata = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
                    2'b01:   e.rdata = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
                    default: e.rdata = word;
                endcase
            end
        end
        return e;
    endfunction

    task automatic mon(input int d);
        exp_t e;
        int   sz;
        sz = (d == 0) ? exp_q0.size() : exp_q1.size();
        if (sz == 0) begin
            check_val($sformatf("resp_expected%0d", d), 32'(sz), 32'd1);
        end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check_val($sformatf("rdata%0d", d), resp_rdata[d], e.rdata);
            check_val($sformatf("err%0d", d), 32'(resp_err[d]), 32'(e.err));
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid[0] === 1'b1) mon(0);
        if (resp_valid[1] === 1'b1) mon(1);
    end

    task automatic xact(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   k, lat;
        lat = (d == 0) ? LAT0 : LAT1;
        e = model(d, we, f3, addr, wdata);
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        @(negedge clk);
        check_val("ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        @(posedge clk);
        #1;
        // inputs are don't-care once accepted
        req_valid[d]  = 1'b0;
        req_we[d]     = 1'($urandom_range(0, 1));
        req_funct3[d] = 3'($urandom_range(0, 7));
        req_addr[d]   = $urandom();
        req_wdata[d]  = $urandom();
        k = 0;
        while (resp_valid[d] !== 1'b1 && k < 40) begin
            check_val("ready_busy", 32'(req_ready[d]), 32'd0);
            @(posedge clk);
            #1;
            k++;
        end
        check_val("latency", 32'(k), 32'(lat + 1));
        check_val("ready_resp", 32'(req_ready[d]), 32'd0);
        @(posedge clk);
        #1;
        check_val("resp_pulse", 32'(resp_valid[d]), 32'd0);
        check_val("ready_back", 32'(req_ready[d]), 32'd1);
        $display("txn dut%0d we=%0d f3=%03b addr=%08h wdata=%08h exp_rdata=%08h exp_err=%0d edges=%0d",
                 d, we, f3, addr, wdata, e.rdata, e.err, k);
    endtask

    logic [2:0] f3_tab [8];

    initial begin
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'd0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_val("rst_ready", 32'(req_ready[d]), 32'd1);
            check_val("rst_valid", 32'(resp_valid[d]), 32'd0);
            check_val("rst_rdata", resp_rdata[d], 32'd0);
            check_val("rst_err", 32'(resp_err[d]), 32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 8; i++) xact(0, 1'b1, 3'b010, 32'(i * 4), $urandom());

        xact(0, 1'b1, 3'b010, 32'd4, 32'hdeadc0de);
        xact(0, 1'b0, 3'b010, 32'd4, 32'd0);
        xact(0, 1'b1, 3'b000, 32'd6, 32'h000000a5);
        xact(0, 1'b0, 3'b000, 32'd6, 32'd0);
        xact(0, 1'b0, 3'b100, 32'd6, 32'd0);
        xact(0, 1'b0, 3'b010, 32'd4, 32'd0);
        xact(0, 1'b1, 3'b001, 32'd2, 32'h00008001);
        xact(0, 1'b0, 3'b001, 32'd2, 32'd0);
        xact(0, 1'b0, 3'b101, 32'd2, 32'd0);
        xact(0, 1'b0, 3'b010, 32'd0, 32'd0);
        xact(0, 1'b0, 3'b010, 32'(4 * DEPTH + 4), 32'd0);
        xact(0, 1'b0, 3'b011, 32'd4, 32'd0);
        xact(0, 1'b0, 3'b110, 32'd4, 32'd0);
        xact(0, 1'b0, 3'b111, 32'd4, 32'd0);
        xact(0, 1'b0, 3'b001, 32'd3, 32'd0);
        xact(0, 1'b1, 3'b010, 32'd5, 32'h12345678);
        xact(0, 1'b0, 3'b010, 32'd4, 32'd0);

        for (int i = 0; i < 24; i++) begin
            logic        we;
            logic [2:0]  f3;
            we = 1'($urandom_range(0, 1));
            f3 = f3_tab[$urandom_range(0, 7)];
            if (we) f3[2] = 1'b0;
            xact(0, we, f3, 32'($urandom_range(0, 31)) + (32'($urandom_range(0, 3)) << 12), $urandom());
        end

        // reset while a store waits: it must be dropped with no response
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b010;
        req_addr[0] = 32'd8; req_wdata[0] = 32'hcafef00d;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("rst_mid_valid", 32'(resp_valid[0]), 32'd0);
            check_val("rst_mid_ready", 32'(req_ready[0]), 32'd1);
        end
        xact(0, 1'b0, 3'b010, 32'd8, 32'd0);

        xact(1, 1'b1, 3'b010, 32'd4, 32'h0badf00d);
        xact(1, 1'b0, 3'b010, 32'(4 * DEPTH + 4), 32'd0);
        xact(1, 1'b1, 3'b000, 32'd7, 32'h00000081);
        xact(1, 1'b0, 3'b000, 32'd7, 32'd0);
        xact(1, 1'b0, 3'b101, 32'd6, 32'd0);
        xact(1, 1'b1, 3'b001, 32'd4, 32'h0000beef);
        xact(1, 1'b0, 3'b010, 32'd4, 32'd0);
        xact(1, 1'b0, 3'b001, 32'd5, 32'd0);

        repeat (3) @(posedge clk);
        check_val("sb_drain0", 32'(exp_q0.size()), 32'd0);
        check_val("sb_drain1", 32'(exp_q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
